// File: rtl/cyc_step_sequencer_if.sv
// rtl/cyc_step_sequencer_if.sv - control, table-write and result bundle of the step sequencer
//
// Purpose: groups every cyc_step_sequencer signal except clk/rst.
//   master modport: the bench/controller side. It drives run and the wr_* table port
//                   and observes the results.
//   slave modport : the sequencer side.
// Ports (as seen from the slave):
//   run      in   start pulse, sampled in IDLE only
//   wr_en    in   table write strobe
//   wr_idx   in   [IW]     table entry to write
//   wr_vld   in   entry valid bit (0 invalidates the entry)
//   wr_cyc   in   [CW]     cycle number the entry matches
//   wr_op    in   [2]      0 DRIVE, 1 FORCE, 2 RELEASE, 3 FINISH
//   wr_val   in   [WIDTH]  drive/force value
//   wr_mask  in   [WIDTH]  force/release bit mask
//   bus_out  out  [WIDTH]  resolved bus
//   cyc_out  out  [CW]     current cycle count
//   step_hit out  a step matched in the previous cycle
//   hit_idx  out  [IW]     index of that step
//   dup_hit  out  more than one valid step matched in the previous cycle
//   done     out  FINISH executed or counter saturated
interface cyc_step_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int NSTEPS = 8,
  parameter int CW     = 32
);
  localparam int IW = $clog2(NSTEPS);

  logic              run;
  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic              wr_vld;
  logic [CW-1:0]     wr_cyc;
  logic [1:0]        wr_op;
  logic [WIDTH-1:0]  wr_val;
  logic [WIDTH-1:0]  wr_mask;
  logic [WIDTH-1:0]  bus_out;
  logic [CW-1:0]     cyc_out;
  logic              step_hit;
  logic [IW-1:0]     hit_idx;
  logic              dup_hit;
  logic              done;

  modport master (
    output run, wr_en, wr_idx, wr_vld, wr_cyc, wr_op, wr_val, wr_mask,
    input  bus_out, cyc_out, step_hit, hit_idx, dup_hit, done
  );

  modport slave (
    input  run, wr_en, wr_idx, wr_vld, wr_cyc, wr_op, wr_val, wr_mask,
    output bus_out, cyc_out, step_hit, hit_idx, dup_hit, done
  );
endinterface

// File: rtl/cyc_step_sequencer.sv
// rtl/cyc_step_sequencer.sv - cycle-indexed drive/force/release/finish step sequencer
//
// Purpose: holds a table of NSTEPS steps. Each step names a cycle number and an action.
//   While running, a free-running cycle counter selects the lowest-indexed valid
//   step whose cycle matches, and that step's action is applied.
//   bus_out = (drv & ~fmask) | (fval & fmask).
// Ports:
//   clk  in  clock; all state changes on the rising edge
//   rst  in  synchronous active-high reset
//   bus  cyc_step_sequencer_if.slave  run/table-write inputs and result outputs
// Optional feature: define STEP_SEQ_DUP_CHECK_EN to build the duplicate-match
//   counter that drives dup_hit. Without it, dup_hit is tied to 0.
module cyc_step_sequencer #(
  parameter int WIDTH  = 4,
  parameter int NSTEPS = 8,
  parameter int CW     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cyc_step_sequencer_if.slave  bus
);
  localparam int IW    = $clog2(NSTEPS);
  // The table is sized to the full index range. A write to an index at or above
  // NSTEPS lands in storage that the match logic never inspects.
  localparam int DEPTH = 1 << IW;

  localparam logic [1:0] OP_DRIVE   = 2'd0;
  localparam logic [1:0] OP_FORCE   = 2'd1;
  localparam logic [1:0] OP_RELEASE = 2'd2;
  localparam logic [1:0] OP_FINISH  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cyc;
  logic [WIDTH-1:0]  drv, fval, fmask;

  logic [DEPTH-1:0]  tab_vld;
  logic [CW-1:0]     tab_cyc  [DEPTH];
  logic [1:0]        tab_op   [DEPTH];
  logic [WIDTH-1:0]  tab_val  [DEPTH];
  logic [WIDTH-1:0]  tab_mask [DEPTH];

  logic [NSTEPS-1:0] match;
  logic              hit;
  logic [IW-1:0]     hit_sel;
  logic              dup;
  logic [WIDTH-1:0]  drv_n, fval_n, fmask_n;

  // Scanning from the top down lets the lowest matching index overwrite hit_sel
  // last, which gives first-match priority.
  always_comb begin
    match   = '0;
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NSTEPS - 1; i >= 0; i--) begin
      if (tab_vld[i] && (tab_cyc[i] == cyc)) begin
        match[i] = 1'b1;
        hit      = 1'b1;
        hit_sel  = IW'(i);
      end
    end
  end

`ifdef STEP_SEQ_DUP_CHECK_EN
  logic [IW:0] match_cnt;
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NSTEPS; i++) begin
      match_cnt = match_cnt + (IW+1)'(match[i]);
    end
  end
  assign dup = (match_cnt >= (IW+1)'(2));
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    drv_n   = drv;
    fval_n  = fval;
    fmask_n = fmask;
    if (hit) begin
      case (tab_op[hit_sel])
        OP_DRIVE:   drv_n = tab_val[hit_sel];
        OP_FORCE: begin
          fmask_n = fmask | tab_mask[hit_sel];
          fval_n  = (fval & ~tab_mask[hit_sel]) | (tab_val[hit_sel] & tab_mask[hit_sel]);
        end
        OP_RELEASE: fmask_n = fmask & ~tab_mask[hit_sel];
        default: ;
      endcase
    end
  end

  assign bus.cyc_out = cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cyc          <= '0;
      drv          <= '0;
      fval         <= '0;
      fmask        <= '0;
      tab_vld      <= '0;
      bus.bus_out  <= '0;
      bus.step_hit <= 1'b0;
      bus.hit_idx  <= '0;
      bus.dup_hit  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      // Table writes are accepted in every state. The match logic reads the
      // pre-edge contents, so a same-edge write and match uses the old entry.
      if (bus.wr_en) begin
        tab_vld[bus.wr_idx]  <= bus.wr_vld;
        tab_cyc[bus.wr_idx]  <= bus.wr_cyc;
        tab_op[bus.wr_idx]   <= bus.wr_op;
        tab_val[bus.wr_idx]  <= bus.wr_val;
        tab_mask[bus.wr_idx] <= bus.wr_mask;
      end

      // step_hit/dup_hit are pulses. They fall in every state unless RUN re-asserts them.
      bus.step_hit <= 1'b0;
      bus.dup_hit  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.run) begin
            state <= RUN;
            cyc   <= '0;
          end
        end
        RUN: begin
          bus.step_hit <= hit;
          bus.dup_hit  <= hit & dup;
          if (hit) bus.hit_idx <= hit_sel;
          drv         <= drv_n;
          fval        <= fval_n;
          fmask       <= fmask_n;
          bus.bus_out <= (drv_n & ~fmask_n) | (fval_n & fmask_n);
          if (hit && (tab_op[hit_sel] == OP_FINISH)) begin
            state    <= DONE;
            bus.done <= 1'b1;
            // The counter never wraps, even when FINISH sits on the last count.
            if (cyc != {CW{1'b1}}) cyc <= cyc + 1'b1;
          end else if (cyc == {CW{1'b1}}) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: ;  // DONE: outputs hold until rst
      endcase
    end
  end
endmodule

// File: tb/tb_cyc_step_sequencer.sv
// tb/tb_cyc_step_sequencer.sv - directed self-checking bench for cyc_step_sequencer
module tb_cyc_step_sequencer;
  localparam logic [1:0] DRIVE = 2'd0, FORCE = 2'd1, RELEASE = 2'd2, FINISH = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cyc_step_sequencer_if #(.WIDTH(4), .NSTEPS(8), .CW(32)) bus ();
  cyc_step_sequencer_if #(.WIDTH(4), .NSTEPS(8), .CW(4))  sbus ();

  cyc_step_sequencer #(.WIDTH(4), .NSTEPS(8), .CW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  cyc_step_sequencer #(.WIDTH(4), .NSTEPS(8), .CW(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  int checks = 0;
  int errors = 0;
  int hits;
  logic [3:0] exp_bus [5] = '{4'h5, 4'h5, 4'h6, 4'h6, 4'h5};
  logic       exp_hit [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       exp_dup;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic vld, input logic [31:0] c,
                    input logic [1:0] op, input logic [3:0] val, input logic [3:0] mask);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_vld = vld; bus.wr_cyc = c;
    bus.wr_op = op; bus.wr_val = val; bus.wr_mask = mask;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef STEP_SEQ_DUP_CHECK_EN
    exp_dup = 1'b1;
`else
    exp_dup = 1'b0;
`endif
    bus.run = 0; bus.wr_en = 0; bus.wr_idx = 0; bus.wr_vld = 0; bus.wr_cyc = 0;
    bus.wr_op = 0; bus.wr_val = 0; bus.wr_mask = 0;
    sbus.run = 0; sbus.wr_en = 0; sbus.wr_idx = 0; sbus.wr_vld = 0; sbus.wr_cyc = 0;
    sbus.wr_op = 0; sbus.wr_val = 0; sbus.wr_mask = 0;
    tick(); tick();
    check("rst_bus",  64'(bus.bus_out), 64'h0);
    check("rst_cyc",  64'(bus.cyc_out), 64'h0);
    check("rst_hit",  64'(bus.step_hit), 64'h0);
    check("rst_idx",  64'(bus.hit_idx), 64'h0);
    check("rst_dup",  64'(bus.dup_hit), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    rst = 1'b0;

    // Basic drive then FINISH at cycle 5
    wr(0, 1, 0, DRIVE, 4'b0101, 4'h0);
    wr(1, 1, 5, FINISH, 4'h0, 4'h0);
    start();
    check("basic_cyc0", 64'(bus.cyc_out), 64'h0);
    tick();
    check("basic_bus", 64'(bus.bus_out), 64'h5);
    check("basic_hit0", 64'(bus.step_hit), 64'h1);
    check("basic_cyc1", 64'(bus.cyc_out), 64'h1);
    hits = 1;
    for (int k = 0; k < 20 && !bus.done; k++) begin
      tick();
      if (bus.step_hit) hits++;
    end
    check("basic_done", 64'(bus.done), 64'h1);
    check("basic_cyc_fin", 64'(bus.cyc_out), 64'h6);
    check("basic_idx", 64'(bus.hit_idx), 64'h1);
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.step_hit) hits++;
    end
    bus.run = 1'b0;
    check("basic_hits", 64'(hits), 64'h2);
    check("basic_hold_cyc", 64'(bus.cyc_out), 64'h6);
    check("basic_hold_bus", 64'(bus.bus_out), 64'h5);
    do_reset();

    // Force a slice at cycle 2, full release at cycle 4
    wr(0, 1, 0, DRIVE, 4'b0101, 4'h0);
    wr(1, 1, 2, FORCE, 4'b0010, 4'b0011);
    wr(2, 1, 4, RELEASE, 4'h0, 4'b1111);
    start();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("fr_bus%0d", k), 64'(bus.bus_out), 64'(exp_bus[k]));
      check($sformatf("fr_hit%0d", k), 64'(bus.step_hit), 64'(exp_hit[k]));
      check($sformatf("fr_cyc%0d", k), 64'(bus.cyc_out), 64'(k + 1));
    end
    do_reset();

    // Two entries on cycle 3: lowest index wins
    wr(2, 1, 3, DRIVE, 4'hA, 4'h0);
    wr(5, 1, 3, DRIVE, 4'hB, 4'h0);
    start();
    tick(); tick(); tick();
    check("dup_pre_bus", 64'(bus.bus_out), 64'h0);
    check("dup_pre_dup", 64'(bus.dup_hit), 64'h0);
    tick();
    check("dup_bus", 64'(bus.bus_out), 64'hA);
    check("dup_idx", 64'(bus.hit_idx), 64'h2);
    check("dup_hit", 64'(bus.dup_hit), 64'(exp_dup));
    tick();
    check("dup_pulse", 64'(bus.dup_hit), 64'h0);
    check("dup_hit_pulse", 64'(bus.step_hit), 64'h0);
    do_reset();

    // Reset mid-run clears state and the table
    wr(0, 1, 1, DRIVE, 4'h7, 4'h0);
    start();
    tick(); tick(); tick();
    check("mid_cyc", 64'(bus.cyc_out), 64'h3);
    check("mid_bus", 64'(bus.bus_out), 64'h7);
    do_reset();
    check("mid_rst_bus", 64'(bus.bus_out), 64'h0);
    check("mid_rst_cyc", 64'(bus.cyc_out), 64'h0);
    start();
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.step_hit) hits++;
    end
    check("mid_nohits", 64'(hits), 64'h0);
    check("mid_nobus", 64'(bus.bus_out), 64'h0);
    do_reset();

    // Write and match on the same entry at the same edge
    wr(1, 1, 2, DRIVE, 4'h5, 4'h0);
    start();
    tick(); tick();
    check("col_cyc", 64'(bus.cyc_out), 64'h2);
    wr(1, 1, 2, DRIVE, 4'hF, 4'h0);
    check("col_old", 64'(bus.bus_out), 64'h5);
    check("col_hit", 64'(bus.step_hit), 64'h1);
    check("col_idx", 64'(bus.hit_idx), 64'h1);
    wr(1, 1, 6, DRIVE, 4'hF, 4'h0);
    tick(); tick();
    check("col_cyc6", 64'(bus.cyc_out), 64'h6);
    check("col_bus6", 64'(bus.bus_out), 64'h5);
    tick();
    check("col_new", 64'(bus.bus_out), 64'hF);
    check("col_new_hit", 64'(bus.step_hit), 64'h1);

    // Saturation on the 4-bit counter instance
    sbus.run = 1'b1;
    tick();
    sbus.run = 1'b0;
    for (int k = 0; k < 40 && !sbus.done; k++) tick();
    check("sat_done", 64'(sbus.done), 64'h1);
    check("sat_cyc", 64'(sbus.cyc_out), 64'hF);
    tick(); tick();
    check("sat_hold", 64'(sbus.cyc_out), 64'hF);
    check("sat_bus", 64'(sbus.bus_out), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
